debug_display_controller: RTL
=============================

// Module: debug_display_controller
// PURPOSE
//  Parametrised successor of the CPU misc/display controller. Selects one of CHANNELS debug words for the display,
//  with an optional auto-scan through the channels. Generates the CPU clock in four modes: fast, slow, single-step, halt.
//  Runs a handshake that halts the CPU while the memory channel is shown.
//  Sits between the CPU statistic counters / data memory and the segment-display driver.
// PARAMETERS
//  CHANNELS     8        number of debug input words (>=2)
//  DATA_WIDTH   32       width of each debug word and of data
//  SEL_WIDTH    3        width of select / current_channel; 2**SEL_WIDTH >= CHANNELS
//  MEM_CHANNEL  1        channel index fed by data memory; showing it halts the CPU
//  MEM_LATENCY  1        clock cycles from memory_address_control rise to valid memory word (>=1)
//  DIV_FAST     5        half-period of clock_out in fast mode, in clock cycles (>=1)
//  DIV_SLOW     1000000  half-period of clock_out in slow mode (>=DIV_FAST)
//  SCAN_PERIOD  50000000 clock cycles per channel in auto-scan (>=2)
// PORTS
//  clock                  in   1                     system clock; everything is rising-edge
//  reset                  in   1                     asynchronous, active-high
//  frequency_mode         in   2                     00 fast, 01 slow, 10 single-step, 11 halt
//  step                   in   1                     single-step request (level, synchronised externally)
//  select                 in   SEL_WIDTH             manual channel select
//  scan_enable            in   1                     1 = auto-scan, select ignored
//  channels               in   CHANNELS*DATA_WIDTH   channel k = bits [k*DATA_WIDTH +: DATA_WIDTH]
//  enable                 out  1                     CPU run enable; 0 while memory channel shown
//  memory_address_control out  1                     1 = memory address comes from display, not CPU
//  data                   out  DATA_WIDTH            registered display word
//  data_valid             out  1                     data reflects the current channel
//  current_channel        out  SEL_WIDTH             effective channel being shown
//  clock_out              out  1                     generated CPU clock
// BEHAVIOUR
//  Reset: all outputs are driven to these values immediately; counters clear; FSM goes to SHOW.
//   clock_out=0, data=0, data_valid=0, enable=1, memory_address_control=0, current_channel=0.
//  Channel select:
//   - eff = scan_enable ? scan_idx : select; current_channel is registered eff (1-cycle latency).
//   - scan_idx advances every SCAN_PERIOD cycles, wraps CHANNELS-1 -> 0, and always skips MEM_CHANNEL.
//   - Scan never halts the CPU. When scan_enable rises, scan_idx restarts at 0 (or 1 if MEM_CHANNEL==0).
//   - eff >= CHANNELS: data=0, data_valid=1.
//  Display FSM (SHOW, MEM_WAIT, MEM_SHOW):
//   - SHOW: data <= channels[eff] every cycle; data_valid=1 from the cycle after reset exit.
//   - SHOW -> MEM_WAIT when eff==MEM_CHANNEL. Same edge: enable<=0, memory_address_control<=1, data_valid<=0,
//     wait counter <= 0.
//   - MEM_WAIT: data holds; after MEM_LATENCY cycles -> MEM_SHOW.
//   - MEM_SHOW: data <= channels[MEM_CHANNEL] every cycle; data_valid=1.
//   - MEM_WAIT/MEM_SHOW -> SHOW when eff!=MEM_CHANNEL. Same edge: enable<=1, memory_address_control<=0;
//     data updates from the new channel on that edge.
//   - A select change to another non-memory channel in SHOW updates data on the next edge; no bubble.
//  Clock generator (counter width = clog2(DIV_SLOW)):
//   - fast/slow: counter counts 0..DIV-1; at DIV-1 clock_out toggles and the counter clears.
//   - Any frequency_mode change clears the counter and holds clock_out's level.
//   - clock_out is forced 0 on entry to single-step or halt.
//   - single-step: a rising edge of step (edge-detected internally) sets clock_out=1 for DIV_FAST cycles, then 0.
//     Edges arriving during a step pulse are ignored.
//   - halt: clock_out stays 0.
//   - enable=0 does not stop clock_out; the CPU gates on enable.
// STRUCTURE
//  Shared package: frequency-mode encodings (MODE_FAST/SLOW/STEP/HALT), FSM state encodings, clog2 function.
//  One sub-module: cpu_clock_generator (frequency_mode, step -> clock_out, with DIV_FAST/DIV_SLOW parameters).
//  Channel mux, scan counter and FSM stay in the top.
// TESTING
//  1. select=2, chan2=32'hDEAD_BEEF, scan off -> data=DEAD_BEEF and data_valid=1 one cycle after select settles.
//     enable=1 throughout.
//  2. select 2->1 (MEM_CHANNEL), MEM_LATENCY=3 -> next edge: enable=0, mem_ctrl=1, valid=0; valid=1 three cycles later
//     with chan1; select->0 restores enable=1 in 1 cycle.
//  3. scan_enable=1, SCAN_PERIOD=4, CHANNELS=4 -> current_channel 0,2,3,0,2 each held 4 cycles.
//     Channel 1 is never shown; enable stays 1.
//  4. fast mode, DIV_FAST=5 -> clock_out period 10 cycles, 50% duty.
//     Switch to step, pulse step twice 20 cycles apart -> two 5-cycle highs.
//  5. Assert reset mid MEM_WAIT and mid step pulse -> all outputs at reset values in the same cycle.
//     After release, FSM is in SHOW and clock_out restarts from 0.
//  6. select=7 with CHANNELS=6 -> data=0, data_valid=1, enable=1.

Source files
------------

// File: rtl/debug_display_controller_pkg.sv
// rtl/debug_display_controller_pkg.sv - shared encodings and helpers for the debug display controller
package debug_display_controller_pkg;

    typedef enum logic [1:0] {
        MODE_FAST = 2'b00,
        MODE_SLOW = 2'b01,
        MODE_STEP = 2'b10,
        MODE_HALT = 2'b11
    } freq_mode_e;

    typedef enum logic [1:0] {
        ST_SHOW     = 2'b00,
        ST_MEM_WAIT = 2'b01,
        ST_MEM_SHOW = 2'b10
    } disp_state_e;

    // Number of bits needed to hold values 0..value-1
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >>> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/debug_display_controller_clock_gen.sv
// rtl/debug_display_controller_clock_gen.sv - CPU clock generator with fast, slow, single-step and halt modes
module cpu_clock_generator
    import debug_display_controller_pkg::*;
#(
    parameter int DIV_FAST = 5,
    parameter int DIV_SLOW = 1000000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] frequency_mode,
    input  logic       step,
    output logic       clock_out
);

    localparam int CNT_W = (clog2(DIV_SLOW) < 1) ? 1 : clog2(DIV_SLOW);
    localparam logic [CNT_W-1:0] FAST_LAST = CNT_W'(DIV_FAST - 1);
    localparam logic [CNT_W-1:0] SLOW_LAST = CNT_W'(DIV_SLOW - 1);

    freq_mode_e       mode;
    freq_mode_e       mode_q;
    logic [CNT_W-1:0] cnt;
    logic             step_q;
    logic             pulse;

    assign mode = freq_mode_e'(frequency_mode);

    // Divider / step pulse generator; a mode change restarts the count and keeps the level
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt       <= '0;
            mode_q    <= MODE_FAST;
            step_q    <= 1'b0;
            pulse     <= 1'b0;
            clock_out <= 1'b0;
        end else begin
            step_q <= step;
            mode_q <= mode;
            if (mode != mode_q) begin
                cnt   <= '0;
                pulse <= 1'b0;
                if (mode == MODE_STEP || mode == MODE_HALT) begin
                    clock_out <= 1'b0;
                end
            end else begin
                case (mode)
                    MODE_FAST, MODE_SLOW: begin
                        if (cnt == ((mode == MODE_FAST) ? FAST_LAST : SLOW_LAST)) begin
                            clock_out <= ~clock_out;
                            cnt       <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    MODE_STEP: begin
                        if (pulse) begin
                            // step edges during an active pulse are deliberately ignored
                            if (cnt == FAST_LAST) begin
                                clock_out <= 1'b0;
                                pulse     <= 1'b0;
                                cnt       <= '0;
                            end else begin
                                cnt <= cnt + 1'b1;
                            end
                        end else if (step && !step_q) begin
                            clock_out <= 1'b1;
                            pulse     <= 1'b1;
                            cnt       <= '0;
                        end
                    end
                    default: begin
                        clock_out <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/debug_display_controller.sv
// rtl/debug_display_controller.sv - debug channel display with auto-scan, memory handshake and CPU clock
module debug_display_controller
    import debug_display_controller_pkg::*;
#(
    parameter int CHANNELS    = 8,
    parameter int DATA_WIDTH  = 32,
    parameter int SEL_WIDTH   = 3,
    parameter int MEM_CHANNEL = 1,
    parameter int MEM_LATENCY = 1,
    parameter int DIV_FAST    = 5,
    parameter int DIV_SLOW    = 1000000,
    parameter int SCAN_PERIOD = 50000000
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [1:0]                     frequency_mode,
    input  logic                           step,
    input  logic [SEL_WIDTH-1:0]           select,
    input  logic                           scan_enable,
    input  logic [CHANNELS*DATA_WIDTH-1:0] channels,
    output logic                           enable,
    output logic                           memory_address_control,
    output logic [DATA_WIDTH-1:0]          data,
    output logic                           data_valid,
    output logic [SEL_WIDTH-1:0]           current_channel,
    output logic                           clock_out
);

    localparam int NSLOT  = 2 ** SEL_WIDTH;
    localparam int SCAN_W = clog2(SCAN_PERIOD);
    localparam int WAIT_W = (clog2(MEM_LATENCY) < 1) ? 1 : clog2(MEM_LATENCY);

    localparam logic [SEL_WIDTH-1:0] MEM_IDX   = SEL_WIDTH'(MEM_CHANNEL);
    localparam logic [SEL_WIDTH-1:0] LAST_IDX  = SEL_WIDTH'(CHANNELS - 1);
    localparam logic [SEL_WIDTH-1:0] FIRST_IDX = (MEM_CHANNEL == 0) ? SEL_WIDTH'(1) : '0;
    localparam logic [SCAN_W-1:0]    SCAN_LAST = SCAN_W'(SCAN_PERIOD - 1);
    localparam logic [WAIT_W-1:0]    WAIT_LAST = WAIT_W'(MEM_LATENCY - 1);

    // Every select code maps to a slot; codes beyond CHANNELS read as zero
    logic [DATA_WIDTH-1:0] slot [NSLOT];

    for (genvar k = 0; k < NSLOT; k++) begin : g_slot
        if (k < CHANNELS) begin : g_used
            assign slot[k] = channels[k*DATA_WIDTH +: DATA_WIDTH];
        end else begin : g_empty
            assign slot[k] = '0;
        end
    end

    function automatic logic [SEL_WIDTH-1:0] wrap_inc(input logic [SEL_WIDTH-1:0] idx);
        return (idx == LAST_IDX) ? '0 : idx + 1'b1;
    endfunction

    logic [SCAN_W-1:0]    scan_cnt;
    logic [SEL_WIDTH-1:0] scan_idx;
    logic [SEL_WIDTH-1:0] scan_next;
    logic [SEL_WIDTH-1:0] eff;
    logic                 is_mem;
    logic [DATA_WIDTH-1:0] word;
    logic [WAIT_W-1:0]    wait_cnt;
    disp_state_e          state;

    // Next scan index, stepping over the memory channel so scanning never halts the CPU
    always_comb begin
        scan_next = wrap_inc(scan_idx);
        if (scan_next == MEM_IDX) begin
            scan_next = wrap_inc(scan_next);
        end
    end

    assign eff    = scan_enable ? scan_idx : select;
    assign is_mem = (eff == MEM_IDX);
    assign word   = slot[eff];

    // Scan timer; parked at the first index while disabled so a fresh scan starts there
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            scan_cnt <= '0;
            scan_idx <= FIRST_IDX;
        end else if (!scan_enable) begin
            scan_cnt <= '0;
            scan_idx <= FIRST_IDX;
        end else if (scan_cnt == SCAN_LAST) begin
            scan_cnt <= '0;
            scan_idx <= scan_next;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

    // Display FSM: plain channels pass straight through, the memory channel stalls the CPU
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state                  <= ST_SHOW;
            wait_cnt               <= '0;
            data                   <= '0;
            data_valid             <= 1'b0;
            enable                 <= 1'b1;
            memory_address_control <= 1'b0;
            current_channel        <= '0;
        end else begin
            current_channel <= eff;
            case (state)
                ST_SHOW: begin
                    if (is_mem) begin
                        state                  <= ST_MEM_WAIT;
                        enable                 <= 1'b0;
                        memory_address_control <= 1'b1;
                        data_valid             <= 1'b0;
                        wait_cnt               <= '0;
                    end else begin
                        data       <= word;
                        data_valid <= 1'b1;
                    end
                end
                ST_MEM_WAIT: begin
                    if (!is_mem) begin
                        state                  <= ST_SHOW;
                        enable                 <= 1'b1;
                        memory_address_control <= 1'b0;
                        data                   <= word;
                        data_valid             <= 1'b1;
                    end else if (wait_cnt == WAIT_LAST) begin
                        // memory word is valid on this edge, MEM_LATENCY cycles after the address switch
                        state      <= ST_MEM_SHOW;
                        data       <= slot[MEM_IDX];
                        data_valid <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: begin
                    if (!is_mem) begin
                        state                  <= ST_SHOW;
                        enable                 <= 1'b1;
                        memory_address_control <= 1'b0;
                        data                   <= word;
                        data_valid             <= 1'b1;
                    end else begin
                        data       <= slot[MEM_IDX];
                        data_valid <= 1'b1;
                    end
                end
            endcase
        end
    end

    cpu_clock_generator #(
        .DIV_FAST (DIV_FAST),
        .DIV_SLOW (DIV_SLOW)
    ) u_clock_gen (
        .clock          (clock),
        .reset          (reset),
        .frequency_mode (frequency_mode),
        .step           (step),
        .clock_out      (clock_out)
    );

endmodule
